// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the parametrised UART/debug FIFO family.
package uart_fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 42;

    // Constant-foldable ceil(log2(value)); clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v / 2;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for uart_sync_fifo: one synchronous write port, one
// asynchronous read address, no reset on the contents.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 42,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO of arbitrary depth with standard or first-word-fall-through
// read, threshold flags, sticky error flags and a synchronous flush.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 40,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int CNT_W   = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  data_count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int            AW   = clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("uart_sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("uart_sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("uart_sync_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));
    assign data_count   = count;

    // A read on an empty FIFO is never served by the same-cycle write.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en & full & ~rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~clr),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout       = mem_rdata;
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              dout_valid_q;

        // dout deliberately holds across a flush; only the qualifier drops.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else if (clr) begin
                dout_valid_q <= 1'b0;
            end else begin
                dout_valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem_rdata;
                end
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed/scoreboard bench for uart_sync_fifo in standard and FWFT modes.
module tb_uart_sync_fifo;

    localparam int D  = 42;
    localparam int AF = 40;
    localparam int AE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dout_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [5:0]  data_count;

    logic        f_clr = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [31:0] f_din = '0;
    logic [31:0] f_dout;
    logic        f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [5:0]  f_count;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_sync_fifo #(.DATA_W(32), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .data_count(data_count), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    uart_sync_fifo #(.DATA_W(32), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
        .dout(f_dout), .dout_valid(f_dv), .data_count(f_count), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus the registered read word.
    logic [31:0] q[$];
    logic [31:0] fq[$];
    logic [31:0] m_dout = '0;
    logic        m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit racc, wacc;
        logic [31:0] tmp;
        if (!rst_n) begin
            q.delete();
            m_dout = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (clr) begin
            q.delete();
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            racc = rd_en && q.size() > 0;
            wacc = wr_en && (q.size() < D || racc);
            if (wr_en && q.size() == D && !rd_en) m_ovf = 1'b1;
            if (rd_en && q.size() == 0) m_udf = 1'b1;
            m_dv = racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(din);
        end
        if (!rst_n || f_clr) begin
            fq.delete();
        end else begin
            racc = f_rd && fq.size() > 0;
            wacc = f_wr && (fq.size() < D || racc);
            if (racc) tmp = fq.pop_front();
            if (wacc) fq.push_back(f_din);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dout", dout, m_dout);
            chk("dout_valid", {31'b0, dout_valid}, {31'b0, m_dv});
            chk("data_count", {26'b0, data_count}, q.size());
            chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
            chk("full", {31'b0, full}, {31'b0, q.size() == D});
            chk("almost_empty", {31'b0, almost_empty}, {31'b0, q.size() <= AE});
            chk("almost_full", {31'b0, almost_full}, {31'b0, q.size() >= AF});
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            chk("underflow", {31'b0, underflow}, {31'b0, m_udf});
            chk("f_count", {26'b0, f_count}, fq.size());
            chk("f_dout_valid", {31'b0, f_dv}, {31'b0, fq.size() > 0});
            if (fq.size() > 0) chk("f_dout", f_dout, fq[0]);
        end
    end

    task automatic drive(input logic c, input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        clr = c; wr_en = w; rd_en = r; din = d;
    endtask

    task automatic fdrive(input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        f_wr = w; f_rd = r; f_din = d;
    endtask

    initial begin
        logic w, r;
        #22 rst_n = 1'b1;
        chk_on = 1'b1;
        drive(0, 0, 0, 0);
        chk("reset empty", {31'b0, empty}, 32'd1);
        chk("reset almost_empty", {31'b0, almost_empty}, 32'd1);

        // fill then drain
        for (int i = 0; i < D; i++) drive(0, 1, 0, i);
        drive(0, 0, 0, 0);
        chk("fill count", {26'b0, data_count}, 32'd42);
        chk("fill full", {31'b0, full}, 32'd1);
        for (int i = 0; i < D; i++) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("drain last word", dout, 32'd41);
        chk("drain empty", {31'b0, empty}, 32'd1);

        // full with simultaneous write and read
        for (int i = 0; i < D; i++) drive(0, 1, 0, 32'h100 + i);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 32'h200 + i);
        drive(0, 0, 0, 0);
        chk("full rw count", {26'b0, data_count}, 32'd42);
        chk("full rw overflow", {31'b0, overflow}, 32'd0);
        chk("full rw word", dout, 32'h104);

        // sticky errors, then flush
        drive(0, 1, 0, 32'hDEAD);
        for (int i = 0; i < D; i++) drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sticky overflow", {31'b0, overflow}, 32'd1);
        chk("sticky underflow", {31'b0, underflow}, 32'd1);
        chk("order after full rw", dout, 32'h204);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("clr overflow", {31'b0, overflow}, 32'd0);
        chk("clr underflow", {31'b0, underflow}, 32'd0);

        // empty with write and read together
        drive(0, 1, 1, 32'h77);
        drive(0, 0, 0, 0);
        chk("empty rw count", {26'b0, data_count}, 32'd1);
        chk("empty rw underflow", {31'b0, underflow}, 32'd1);
        drive(1, 0, 0, 0);

        // random traffic across several pointer wraps
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 32'h3000 + i);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (q.size() <= 1 && r && !w) r = 1'b0;
            if (q.size() >= 41 && w && !r) w = 1'b0;
            clr = 1'b0; wr_en = w; rd_en = r; din = $urandom;
        end
        drive(0, 0, 0, 0);
        chk("wrap no overflow", {31'b0, overflow}, 32'd0);
        chk("wrap no underflow", {31'b0, underflow}, 32'd0);

        // reset mid-burst at count 17
        drive(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) drive(0, 1, 0, 32'h500 + i);
        drive(0, 1, 0, 32'h999);
        chk("pre-reset count", {26'b0, data_count}, 32'd17);
        #2 rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rst count", {26'b0, data_count}, 32'd0);
        chk("rst empty", {31'b0, empty}, 32'd1);
        chk("rst almost_empty", {31'b0, almost_empty}, 32'd1);
        chk("rst dout_valid", {31'b0, dout_valid}, 32'd0);
        chk("rst dout", dout, 32'd0);
        chk("rst full", {31'b0, full}, 32'd0);
        chk("rst almost_full", {31'b0, almost_full}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // flush concurrent with write
        drive(1, 1, 0, 32'hBEEF);
        drive(0, 0, 0, 0);
        chk("clr+wr count", {26'b0, data_count}, 32'd0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("clr+wr nothing read", {31'b0, dout_valid}, 32'd0);

        // FWFT mode
        fdrive(1, 0, 32'hA5A5_0001);
        fdrive(0, 0, 0);
        chk("fwft dout", f_dout, 32'hA5A5_0001);
        chk("fwft valid", {31'b0, f_dv}, 32'd1);
        fdrive(0, 1, 0);
        fdrive(0, 0, 0);
        chk("fwft pop valid", {31'b0, f_dv}, 32'd0);
        chk("fwft pop empty", {31'b0, f_empty}, 32'd1);
        fdrive(1, 0, 32'h11);
        fdrive(1, 1, 32'h22);
        fdrive(0, 0, 0);
        chk("fwft second word", f_dout, 32'h22);
        fdrive(0, 1, 0);
        fdrive(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
